// File: rtl/l1_l2_arbiter.sv
// ---------------------------------------------------------------------------
// l1_l2_arbiter
//   Shares the single L2 request port between the L1 I-cache controller and
//   the L1 D-cache controller. One requester owns the port at a time, its
//   command/tag/index are registered onto the L2 port, and l2_ready is routed
//   back to the owner only. Sides alternate round-robin, except that a D-side
//   write-back locks the port to D until the following allocate read (or
//   until LOCK_TO cycles pass without that read).
//
// Ports
//   clk, nrst              clock, asynchronous active-low reset
//   i_read/i_tag/i_index   I-side line-fill request (held until i_ready)
//   i_ready                l2_ready routed to the I-side
//   d_read/d_write         D-side allocate read / write-back requests
//   d_tag/d_write_tag      D-side allocate tag / victim tag
//   d_index                D-side set index
//   d_ready                l2_ready routed to the D-side
//   l2_read/l2_write       registered command to L2 (never both)
//   l2_tag/l2_index        registered address to L2
//   l2_ready               L2 transfer complete (single-cycle pulse)
//   owner                  0 = I-side, 1 = D-side (valid while busy)
//   busy                   a grant is active
// ---------------------------------------------------------------------------
module l1_l2_arbiter #(
   parameter int TAG_W   = 21,
   parameter int IDX_W   = 5,
   parameter int LOCK_TO = 15
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             i_read,
   input  logic [TAG_W-1:0] i_tag,
   input  logic [IDX_W-1:0] i_index,
   output logic             i_ready,
   input  logic             d_read,
   input  logic             d_write,
   input  logic [TAG_W-1:0] d_tag,
   input  logic [TAG_W-1:0] d_write_tag,
   input  logic [IDX_W-1:0] d_index,
   output logic             d_ready,
   output logic             l2_read,
   output logic             l2_write,
   output logic [TAG_W-1:0] l2_tag,
   output logic [IDX_W-1:0] l2_index,
   input  logic             l2_ready,
   output logic             owner,
   output logic             busy
);

   // Lock counter runs 0 .. LOCK_TO-1; reaching LOCK_TO releases the lock.
   localparam int CNT_W = (LOCK_TO > 1) ? $clog2(LOCK_TO) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_GRANT_I,
      S_GRANT_D,
      S_RELEASE
   } state_t;

   state_t           r_state, w_state_nxt;
   logic             r_last_owner, w_last_owner_nxt;
   logic             r_lock_d, w_lock_d_nxt;
   logic [CNT_W-1:0] r_lock_cnt, w_lock_cnt_nxt;
   logic             r_l2_read, w_l2_read_nxt;
   logic             r_l2_write, w_l2_write_nxt;
   logic [TAG_W-1:0] r_l2_tag, w_l2_tag_nxt;
   logic [IDX_W-1:0] r_l2_index, w_l2_index_nxt;
   logic             r_owner, w_owner_nxt;
   logic             r_busy, w_busy_nxt;
   logic             w_grant_i, w_grant_d;
   logic             w_d_req;

   assign w_d_req = d_read | d_write;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_state      <= S_IDLE;
         r_last_owner <= 1'b1;
         r_lock_d     <= 1'b0;
         r_lock_cnt   <= '0;
         r_l2_read    <= 1'b0;
         r_l2_write   <= 1'b0;
         r_l2_tag     <= '0;
         r_l2_index   <= '0;
         r_owner      <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_last_owner <= w_last_owner_nxt;
         r_lock_d     <= w_lock_d_nxt;
         r_lock_cnt   <= w_lock_cnt_nxt;
         r_l2_read    <= w_l2_read_nxt;
         r_l2_write   <= w_l2_write_nxt;
         r_l2_tag     <= w_l2_tag_nxt;
         r_l2_index   <= w_l2_index_nxt;
         r_owner      <= w_owner_nxt;
         r_busy       <= w_busy_nxt;
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_last_owner_nxt = r_last_owner;
      w_lock_d_nxt     = r_lock_d;
      w_lock_cnt_nxt   = r_lock_cnt;
      w_l2_read_nxt    = r_l2_read;
      w_l2_write_nxt   = r_l2_write;
      w_l2_tag_nxt     = r_l2_tag;
      w_l2_index_nxt   = r_l2_index;
      w_owner_nxt      = r_owner;
      w_busy_nxt       = r_busy;
      w_grant_i        = 1'b0;
      w_grant_d        = 1'b0;

      // The lock only ages while D is not actually using the port.
      if (r_lock_d && (r_state != S_GRANT_D)) begin
         if (r_lock_cnt == CNT_W'(LOCK_TO - 1)) begin
            w_lock_d_nxt   = 1'b0;
            w_lock_cnt_nxt = '0;
         end else begin
            w_lock_cnt_nxt = r_lock_cnt + CNT_W'(1);
         end
      end

      case (r_state)
         S_IDLE: begin
            if (r_lock_d) begin
               w_grant_d = d_read;
            end else if (i_read && w_d_req) begin
               // last_owner = 1 means D went last, so I is due.
               w_grant_i = r_last_owner;
               w_grant_d = ~r_last_owner;
            end else begin
               w_grant_i = i_read;
               w_grant_d = w_d_req;
            end

            if (w_grant_i) begin
               w_state_nxt    = S_GRANT_I;
               w_l2_read_nxt  = 1'b1;
               w_l2_write_nxt = 1'b0;
               w_l2_tag_nxt   = i_tag;
               w_l2_index_nxt = i_index;
               w_owner_nxt    = 1'b0;
               w_busy_nxt     = 1'b1;
            end else if (w_grant_d) begin
               // Write-back wins over allocate; latched for the whole grant.
               w_state_nxt    = S_GRANT_D;
               w_l2_read_nxt  = ~d_write;
               w_l2_write_nxt = d_write;
               w_l2_tag_nxt   = d_write ? d_write_tag : d_tag;
               w_l2_index_nxt = d_index;
               w_owner_nxt    = 1'b1;
               w_busy_nxt     = 1'b1;
            end
         end

         S_GRANT_I, S_GRANT_D: begin
            if (l2_ready) begin
               w_state_nxt      = S_RELEASE;
               w_last_owner_nxt = (r_state == S_GRANT_D);
               w_l2_read_nxt    = 1'b0;
               w_l2_write_nxt   = 1'b0;
               w_l2_tag_nxt     = '0;
               w_l2_index_nxt   = '0;
               w_owner_nxt      = 1'b0;
               w_busy_nxt       = 1'b0;
               if (r_state == S_GRANT_D) begin
                  // A finished write-back pins the port for its allocate read;
                  // a finished read releases it.
                  w_lock_d_nxt   = r_l2_write;
                  w_lock_cnt_nxt = '0;
               end
            end
         end

         S_RELEASE: begin
            w_state_nxt = S_IDLE;
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign i_ready  = l2_ready & (r_state == S_GRANT_I);
   assign d_ready  = l2_ready & (r_state == S_GRANT_D);
   assign l2_read  = r_l2_read;
   assign l2_write = r_l2_write;
   assign l2_tag   = r_l2_tag;
   assign l2_index = r_l2_index;
   assign owner    = r_owner;
   assign busy     = r_busy;

endmodule

// File: doc/l1_l2_arbiter.md
Name: l1_l2_arbiter

Overview:
- Shares the single L2 request port between the L1 instruction-cache controller (I-side) and the L1 data-cache controller (D-side).
- Grants one requester at a time, forwards its tag/index/command to L2, and routes the L2 ready back to the owner only.
- Round-robin between sides. A D-side write-back is locked to the allocate read that follows it, so no I-side transfer can interleave.

Parameters:
- TAG_W, 21, tag width.
- IDX_W, 5, set index width.
- LOCK_TO, 15, maximum cycles the D-side lock is held waiting for the allocate read.

Ports:
- clk  in  1  clock
- nrst  in  1  reset
- i_read  in  1  I-side line-fill request (level, held until i_ready seen)
- i_tag  in  TAG_W  I-side request tag
- i_index  in  IDX_W  I-side request index
- i_ready  out  1  L2 ready routed to I-side
- d_read  in  1  D-side allocate request
- d_write  in  1  D-side write-back request
- d_tag  in  TAG_W  D-side allocate tag
- d_write_tag  in  TAG_W  D-side victim tag for write-back
- d_index  in  IDX_W  D-side index
- d_ready  out  1  L2 ready routed to D-side
- l2_read  out  1  read command to L2
- l2_write  out  1  write command to L2
- l2_tag  out  TAG_W  tag to L2
- l2_index  out  IDX_W  index to L2
- l2_ready  in  1  L2 transfer complete (single-cycle pulse)
- owner  out  1  0 = I-side, 1 = D-side (valid while busy)
- busy  out  1  a grant is active

Behaviour:
- Reset (nrst asynchronous, active-low; clock clk): state S_IDLE, last_owner=1 (I-side wins the first tie), lock_d=0, lock counter 0. All outputs 0.
- States:
  - S_IDLE: no grant active.
  - S_GRANT_I: I-side owns the L2 port.
  - S_GRANT_D: D-side owns the L2 port.
  - S_RELEASE: one dead cycle after each completion. Requesters drop their registered request one cycle after ready, so requests are ignored here. Always returns to S_IDLE.
- S_IDLE selection, registered into the grant state on the next edge:
  - If lock_d=1: only D is considered. Go to S_GRANT_D when d_read; I is blocked.
  - Else, both sides requesting: grant the side not equal to last_owner.
  - Else: grant whichever side is requesting.
  - No request: stay in S_IDLE.
- D-side command selection on entry to S_GRANT_D: d_write has priority over d_read when both are high. The chosen command is latched for the whole grant.
- Outputs in a grant state (registered, valid from the first grant cycle until l2_ready):
  - l2_read = 1 for I, D-read. l2_write = 1 for D-write, never together with l2_read.
  - l2_tag = i_tag for I, d_tag for D-read, d_write_tag for D-write.
  - l2_index = index of the owner.
  - busy=1; owner reflects the grant state.
- Ready routing (combinational): i_ready = l2_ready & S_GRANT_I; d_ready = l2_ready & S_GRANT_D. l2_ready in S_IDLE or S_RELEASE is ignored and not forwarded.
- Completion: on l2_ready in a grant state, go to S_RELEASE, set last_owner to the current owner, and deassert l2_read/l2_write the next cycle.
  - D-write completion sets lock_d=1 and clears the counter.
  - D-read completion clears lock_d.
- Lock timeout: while lock_d=1 and not in S_GRANT_D, the counter increments each cycle. When it reaches LOCK_TO, lock_d clears and the counter returns to 0.
- Latency: request seen in S_IDLE -> l2_read/l2_write high 1 cycle later. Minimum back-to-back gap is 2 cycles (S_RELEASE, S_IDLE).
- Requester drops its request mid-grant: the grant is held until l2_ready (L2 transactions are not aborted).
- Reset mid-grant: immediate return to S_IDLE, all outputs 0, lock cleared.

Test Plan:
- i_read=1 alone, i_tag=0x1ABCD, i_index=3; l2_ready after 4 cycles:
  - l2_read=1, l2_tag=0x1ABCD, l2_index=3 one cycle after the request.
  - i_ready pulses with l2_ready; d_ready stays 0.
  - busy falls 1 cycle later.
- i_read and d_read rise in the same cycle from reset: I is granted first; D is granted 2 cycles after I's l2_ready. With both held continuously, grants alternate I, D, I.
- d_write=1 and d_read=1, d_write_tag=0x00055, d_tag=0x000AA, i_read=1:
  - First l2_write with tag 0x00055.
  - After ready, the next grant is D-read with tag 0x000AA; I waits despite round-robin.
- Lock timeout: D-write completes, d_read never asserts, i_read held. lock_d clears after 15 cycles and I is then granted.
- l2_ready pulsed in S_IDLE with no grant active: no i_ready/d_ready, no state change.
- Reset mid-grant: nrst low during S_GRANT_D with l2_write=1. All outputs 0 immediately; after release, a fresh i_read is granted normally.
